// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: address-width calculation and pointer-based full/empty tests.
// Used by the single-clock core and the dual-clock variant.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic int addr_w(input int size);
    return $clog2(size);
  endfunction

  // Pointers are passed zero-extended; aw is the address width, so bit aw is the wrap bit.
  function automatic logic ptr_empty(input logic [PTR_MAX_W-1:0] rd,
                                     input logic [PTR_MAX_W-1:0] wr);
    return rd == wr;
  endfunction

  // Full when only the wrap bit differs.
  function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] rd,
                                    input logic [PTR_MAX_W-1:0] wr,
                                    input int unsigned aw);
    return (rd ^ wr) == (PTR_MAX_W'(1) << aw);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Dual-port register storage: synchronous write port, registered read port with enable.
// The array itself is never reset; only the read register is.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int WIDTH = 4,
  localparam int AW   = addr_w(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync_core.sv
// Single-clock FIFO core: binary pointers one bit wider than the address, flags and storage.
// Define FIFO_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module fifo_sync_core
  import fifo_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int WIDTH = $clog2(SIZE) + 1,
  localparam int AW   = addr_w(SIZE)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             w_en,
  input  logic             r_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      read_ptr,
  output logic [AW:0]      wrt_ptr
`ifdef FIFO_ERR_FLAG_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  logic [AW:0] rd_ptr_d, rd_ptr_q;
  logic [AW:0] wr_ptr_d, wr_ptr_q;
  logic        wr_acc;
  logic        rd_acc;

  assign empty = ptr_empty(PTR_MAX_W'(rd_ptr_q), PTR_MAX_W'(wr_ptr_q));
  assign full  = ptr_full(PTR_MAX_W'(rd_ptr_q), PTR_MAX_W'(wr_ptr_q), AW);

  always_comb begin
    wr_acc   = w_en && !full;
    rd_acc   = r_en && !empty;
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_acc);
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_acc);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Reset blocks the write strobe so a discarded cycle leaves storage untouched.
  fifo_ram #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (srst),
    .we    (wr_acc && !srst),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (data_in),
    .re    (rd_acc),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (data_out)
  );

  assign read_ptr = rd_ptr_q;
  assign wrt_ptr  = wr_ptr_q;

`ifdef FIFO_ERR_FLAG_EN
  logic ovf_d, ovf_q;
  logic unf_d, unf_q;

  always_comb begin
    ovf_d = ovf_q || (w_en && full);
    unf_d = unf_q || (r_en && empty);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_sync_core.sv
// Self-checking bench for fifo_sync_core: a reference queue model feeds a scoreboard of
// expected read words; pointers, flags and data_out are compared after every edge.
module tb_fifo_sync_core;

  localparam int SIZE  = 8;
  localparam int WIDTH = 4;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             srst = 1'b0;
  logic             w_en = 1'b0;
  logic             r_en = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [AW:0]      read_ptr;
  logic [AW:0]      wrt_ptr;
`ifdef FIFO_ERR_FLAG_EN
  logic             overflow;
  logic             underflow;
`endif

  fifo_sync_core #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .srst     (srst),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .read_ptr (read_ptr),
    .wrt_ptr  (wrt_ptr)
`ifdef FIFO_ERR_FLAG_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [AW:0]      m_rd;
  logic [AW:0]      m_wr;
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf;
  logic             m_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive, advance model using pre-edge occupancy, then compare.
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d,
                      input logic rst = 1'b0);
    bit wa, ra;
    w_en    = w;
    r_en    = r;
    data_in = d;
    srst    = rst;
    wa = w && (mq.size() < SIZE);
    ra = r && (mq.size() > 0);
    if (rst) begin
      mq.delete();
      exp_q.delete();
      m_rd   = '0;
      m_wr   = '0;
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      if (w && mq.size() == SIZE) m_ovf = 1'b1;
      if (r && mq.size() == 0)    m_unf = 1'b1;
      if (ra) begin
        exp_q.push_back(mq.pop_front());
        m_rd = m_rd + 1'b1;
      end
      if (wa) begin
        mq.push_back(d);
        m_wr = m_wr + 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) m_dout = exp_q.pop_front();
    check("data_out", 32'(data_out), 32'(m_dout));
    check("empty",    32'(empty),    32'(mq.size() == 0));
    check("full",     32'(full),     32'(mq.size() == SIZE));
    check("read_ptr", 32'(read_ptr), 32'(m_rd));
    check("wrt_ptr",  32'(wrt_ptr),  32'(m_wr));
`ifdef FIFO_ERR_FLAG_EN
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] held;

    // Reset then idle
    step(1'b0, 1'b0, '0, 1'b1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout",  32'(data_out), 32'd0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Write 1,2,3 then read them back in order
    step(1'b1, 1'b0, 4'd1);
    step(1'b1, 1'b0, 4'd2);
    step(1'b1, 1'b0, 4'd3);
    step(1'b0, 1'b1, '0);
    check("rd1", 32'(data_out), 32'd1);
    step(1'b0, 1'b1, '0);
    check("rd2", 32'(data_out), 32'd2);
    step(1'b0, 1'b1, '0);
    check("rd3", 32'(data_out), 32'd3);
    check("empty_after_rd3", 32'(empty), 32'd1);

    // Fill from reset; 9th write must be ignored
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < SIZE; i++) step(1'b1, 1'b0, 4'(i + 8));
    check("full_after_8", 32'(full), 32'd1);
    check("wptr_after_8", 32'(wrt_ptr), 32'd8);
    step(1'b1, 1'b0, 4'hf);
    check("wptr_after_9", 32'(wrt_ptr), 32'd8);

    // Full with both requests: read only
    step(1'b1, 1'b1, 4'h5);
    check("full_rw_full", 32'(full), 32'd0);
    check("full_rw_dout", 32'(data_out), 32'd8);

    // Drain, then read while empty
    while (mq.size() > 0) step(1'b0, 1'b1, '0);
    held = data_out;
    step(1'b0, 1'b1, '0);
    check("empty_rd_dout", 32'(data_out), 32'(held));
`ifdef FIFO_ERR_FLAG_EN
    check("underflow_set", 32'(underflow), 32'd1);
`endif

    // Empty with both requests: write only, no forwarding
    step(1'b1, 1'b1, 4'h6);
    check("empty_rw_dout",  32'(data_out), 32'(held));
    check("empty_rw_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, '0);
    check("empty_rw_word", 32'(data_out), 32'd6);

    // 20 write/read pairs from reset: pointers wrap past 15
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      step(1'b0, 1'b1, '0);
    end
    check("wrap_rptr", 32'(read_ptr), 32'd4);

    // Random mix, then reset mid-stream
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)));
    step(1'b1, 1'b1, 4'h9, 1'b1);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_rptr",  32'(read_ptr), 32'd0);
    check("midrst_wptr",  32'(wrt_ptr), 32'd0);
    step(1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
